// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin front end for a single i2c_master: grants one requester,
// runs its single transaction through the master and reports done/err/rdata.
module i2c_req_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [7:0]        rdata,
  output logic              m_enable,
  output logic              m_rw,
  output logic              m_restart,
  output logic [ADDR_W-1:0] m_address,
  output logic [7:0]        m_txdata,
  input  logic              m_ready,
  input  logic              m_ack,
  input  logic [7:0]        m_rxdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             timed_out;
  logic             last_winner;
  logic             winner;
  logic             pick;
  logic [1:0]       winner_onehot;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) begin
      pick = ~last_winner;
    end
  end

  assign count_next    = count + CNT_W'(1);
  assign timed_out     = (count_next == CNT_W'(TIMEOUT));
  assign winner_onehot = {winner, ~winner};
  assign m_restart     = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 2'b00;
      done        <= 2'b00;
      err         <= 2'b00;
      rdata       <= 8'h00;
      m_enable    <= 1'b0;
      m_rw        <= 1'b0;
      m_address   <= '0;
      m_txdata    <= 8'h00;
      count       <= '0;
      last_winner <= 1'b1;
      winner      <= 1'b0;
    end else begin
      done <= 2'b00;
      err  <= 2'b00;
      case (state)
        IDLE: begin
          if ((req != 2'b00) && m_ready) begin
            winner    <= pick;
            grant     <= {pick, ~pick};
            m_address <= pick ? addr1 : addr0;
            m_rw      <= pick ? rw1 : rw0;
            m_txdata  <= pick ? wdata1 : wdata0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          m_enable <= 1'b1;
          count    <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!m_ready) begin
            m_enable <= 1'b0;
            count    <= '0;
            state    <= WAIT_DONE;
          end else if (timed_out) begin
            m_enable <= 1'b0;
            count    <= count_next;
            grant    <= 2'b00;
            done     <= winner_onehot;
            err      <= winner_onehot;
            state    <= COMPLETE;
          end else begin
            count <= count_next;
          end
        end
        WAIT_DONE: begin
          // A timeout here reports an error but leaves the previous read byte in place.
          if (m_ready) begin
            rdata <= m_rxdata;
            grant <= 2'b00;
            done  <= winner_onehot;
            err   <= m_ack ? 2'b00 : winner_onehot;
            state <= COMPLETE;
          end else if (timed_out) begin
            count <= count_next;
            grant <= 2'b00;
            done  <= winner_onehot;
            err   <= winner_onehot;
            state <= COMPLETE;
          end else begin
            count <= count_next;
          end
        end
        COMPLETE: begin
          last_winner <= winner;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomised bench for i2c_req_arbiter: an emulated i2c_master plus a transaction-level
// reference model compared against the DUT every cycle, with directed literal checks.
module tb_i2c_req_arbiter;

  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              rw0, rw1;
  logic [7:0]        wdata0, wdata1;
  logic [1:0]        grant, done, err;
  logic [7:0]        rdata;
  logic              m_enable, m_rw, m_restart;
  logic [ADDR_W-1:0] m_address;
  logic [7:0]        m_txdata;
  logic              m_ready, m_ack;
  logic [7:0]        m_rxdata;

  int checks = 0;
  int errors = 0;

  i2c_req_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .addr1(addr1), .rw0(rw0), .rw1(rw1),
    .wdata0(wdata0), .wdata1(wdata1),
    .grant(grant), .done(done), .err(err), .rdata(rdata),
    .m_enable(m_enable), .m_rw(m_rw), .m_restart(m_restart),
    .m_address(m_address), .m_txdata(m_txdata),
    .m_ready(m_ready), .m_ack(m_ack), .m_rxdata(m_rxdata)
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs plus the transaction in flight.
  logic [1:0]        e_grant = 2'b00, e_done = 2'b00, e_err = 2'b00;
  logic [7:0]        e_rdata = 8'h00, e_txdata = 8'h00;
  logic              e_enable = 1'b0, e_rw = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  bit                mdl_active = 1'b0, mdl_started = 1'b0, mdl_seen_busy = 1'b0;
  int                mdl_wait = 0, mdl_win = 0, mdl_last = 1;

  // Emulated i2c_master.
  int         s_phase = 0, s_cnt = 0, s_mode = 0, force_mode = 0;
  logic [7:0] force_rx = 8'h00;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name, input int limit);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no event, expected one within %0d cycles", name, limit);
  endtask

  task automatic modelFinish(input bit failed, input bit capture);
    e_enable   = 1'b0;
    e_grant    = 2'b00;
    e_done     = (mdl_win == 1) ? 2'b10 : 2'b01;
    e_err      = failed ? e_done : 2'b00;
    if (capture) e_rdata = m_rxdata;
    mdl_last   = mdl_win;
    mdl_active = 1'b0;
  endtask

  task automatic modelStep();
    if (reset) begin
      e_grant = 2'b00; e_done = 2'b00; e_err = 2'b00; e_rdata = 8'h00;
      e_enable = 1'b0; e_rw = 1'b0; e_addr = '0; e_txdata = 8'h00;
      mdl_active = 1'b0; mdl_last = 1;
      return;
    end
    if (e_done != 2'b00) begin
      e_done = 2'b00;
      e_err  = 2'b00;
      return;
    end
    if (!mdl_active) begin
      if ((req != 2'b00) && m_ready) begin
        if (req == 2'b11) mdl_win = 1 - mdl_last;
        else mdl_win = req[1] ? 1 : 0;
        e_grant     = (mdl_win == 1) ? 2'b10 : 2'b01;
        e_addr      = (mdl_win == 1) ? addr1 : addr0;
        e_rw        = (mdl_win == 1) ? rw1 : rw0;
        e_txdata    = (mdl_win == 1) ? wdata1 : wdata0;
        mdl_active  = 1'b1;
        mdl_started = 1'b0;
      end
      return;
    end
    if (!mdl_started) begin
      e_enable      = 1'b1;
      mdl_started   = 1'b1;
      mdl_seen_busy = 1'b0;
      mdl_wait      = 0;
      return;
    end
    mdl_wait++;
    if (!mdl_seen_busy) begin
      if (!m_ready) begin
        e_enable      = 1'b0;
        mdl_seen_busy = 1'b1;
        mdl_wait      = 0;
      end else if (mdl_wait == TIMEOUT) begin
        modelFinish(1'b1, 1'b0);
      end
    end else begin
      if (m_ready) modelFinish(!m_ack, 1'b1);
      else if (mdl_wait == TIMEOUT) modelFinish(1'b1, 1'b0);
    end
  endtask

  task automatic checkOutput();
    compare("grant", 32'(grant), 32'(e_grant));
    compare("done", 32'(done), 32'(e_done));
    compare("err", 32'(err), 32'(e_err));
    compare("rdata", 32'(rdata), 32'(e_rdata));
    compare("m_enable", 32'(m_enable), 32'(e_enable));
    compare("m_address", 32'(m_address), 32'(e_addr));
    compare("m_rw", 32'(m_rw), 32'(e_rw));
    compare("m_txdata", 32'(m_txdata), 32'(e_txdata));
    compare("m_restart", 32'(m_restart), 32'd0);
    compare("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    compare("done_onehot", 32'($countones(done) <= 1), 32'd1);
  endtask

  // Modes: 1 ack, 2 nack, 3 never goes busy, 4 stays busy past the timeout.
  task automatic slaveStep();
    case (s_phase)
      0: if (m_enable) begin
        if (force_mode != 0) s_mode = force_mode;
        else begin
          s_cnt = $urandom_range(0, 19);
          s_mode = (s_cnt < 13) ? 1 : (s_cnt < 16) ? 2 : (s_cnt < 18) ? 3 : 4;
        end
        if (s_mode == 3) s_phase = 3;
        else begin
          s_phase = 1;
          s_cnt = $urandom_range(0, 3);
        end
      end
      1: if (s_cnt == 0) begin
        m_ready = 1'b0;
        s_phase = 2;
        s_cnt = (s_mode == 4) ? TIMEOUT + 4 : $urandom_range(0, 5);
      end else s_cnt--;
      2: if (s_cnt == 0) begin
        m_ready  = 1'b1;
        m_ack    = (s_mode != 2);
        m_rxdata = (force_mode != 0) ? force_rx : 8'($urandom);
        s_phase  = 0;
      end else s_cnt--;
      3: if (!m_enable) s_phase = 0;
      default: s_phase = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    slaveStep();
  endtask

  task automatic waitDone(input string name, input int limit, output logic [1:0] d);
    d = 2'b00;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (done != 2'b00) begin
        d = done;
        return;
      end
    end
    reportFail(name, limit);
  endtask

  task automatic randField(input int i);
    if (i == 0) begin
      addr0 = 7'($urandom); rw0 = 1'($urandom); wdata0 = 8'($urandom);
    end else begin
      addr1 = 7'($urandom); rw1 = 1'($urandom); wdata1 = 8'($urandom);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      if (req[i] && done[i]) begin
        if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
      end else if (req[i] && ($urandom_range(0, 99) < 2)) begin
        req[i] = 1'b0;
      end else if (!req[i] && ($urandom_range(0, 9) < 3)) begin
        req[i] = 1'b1;
        randField(i);
      end
      if ($urandom_range(0, 9) == 0) randField(i);
    end
    reset = ($urandom_range(0, 399) == 0);
  endtask

  initial begin
    logic [1:0] d;
    int         cnt;
    bit         seen;

    reset = 1'b1; req = 2'b00;
    addr0 = '0; addr1 = '0; rw0 = 1'b0; rw1 = 1'b0; wdata0 = 8'h00; wdata1 = 8'h00;
    m_ready = 1'b1; m_ack = 1'b0; m_rxdata = 8'h00;
    tick();
    tick();
    compare("rst_grant", 32'(grant), 32'd0);
    compare("rst_enable", 32'(m_enable), 32'd0);
    compare("rst_rdata", 32'(rdata), 32'd0);
    compare("rst_address", 32'(m_address), 32'd0);
    reset = 1'b0;
    tick();

    // Write to 0x50; inputs are scrambled after grant to prove the fields were latched.
    force_mode = 1; force_rx = 8'h11;
    req = 2'b01; addr0 = 7'h50; rw0 = 1'b0; wdata0 = 8'hA5;
    tick();
    compare("wr_grant", 32'(grant), 32'h1);
    compare("wr_addr", 32'(m_address), 32'h50);
    compare("wr_txdata", 32'(m_txdata), 32'hA5);
    compare("wr_enable_at_grant", 32'(m_enable), 32'd0);
    addr0 = 7'h7F; wdata0 = 8'h00;
    tick();
    compare("wr_enable_latency", 32'(m_enable), 32'd1);
    compare("wr_addr_held", 32'(m_address), 32'h50);
    waitDone("wr_done_wait", 100, d);
    compare("wr_done", 32'(d), 32'h1);
    compare("wr_err", 32'(err), 32'h0);
    req = 2'b00;
    tick(); tick();

    // Read from requester 1.
    force_rx = 8'h3C;
    req = 2'b10; addr1 = 7'h51; rw1 = 1'b1; wdata1 = 8'h00;
    tick();
    compare("rd_grant", 32'(grant), 32'h2);
    compare("rd_rw", 32'(m_rw), 32'h1);
    waitDone("rd_done_wait", 100, d);
    compare("rd_done", 32'(d), 32'h2);
    compare("rd_err", 32'(err), 32'h0);
    compare("rd_rdata", 32'(rdata), 32'h3C);
    req = 2'b00;
    tick(); tick();

    // Absent slave NACKs.
    force_mode = 2; force_rx = 8'h99;
    req = 2'b01; addr0 = 7'h52;
    waitDone("nack_done_wait", 100, d);
    compare("nack_done", 32'(d), 32'h1);
    compare("nack_err", 32'(err), 32'h1);
    req = 2'b00;
    tick(); tick();

    // Master never goes busy: enable must stay up exactly TIMEOUT cycles.
    force_mode = 3;
    req = 2'b01; addr0 = 7'h50;
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (m_enable) cnt++;
      if (done != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportFail("to_done_wait", 100);
    compare("to_enable_cycles", 32'(cnt), 32'd16);
    compare("to_err", 32'(err), 32'h1);
    compare("to_rdata_kept", 32'(rdata), 32'h99);
    compare("to_enable_off", 32'(m_enable), 32'd0);
    req = 2'b00;
    tick(); tick();

    // Both request after reset: 0 first, then 1, then 0 again while both stay high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    force_mode = 1; force_rx = 8'h5A;
    req = 2'b11; addr0 = 7'h10; addr1 = 7'h20;
    tick();
    compare("rr_first_grant", 32'(grant), 32'h1);
    waitDone("rr_first_wait", 100, d);
    compare("rr_first_done", 32'(d), 32'h1);
    tick(); tick();
    compare("rr_second_grant", 32'(grant), 32'h2);
    compare("rr_second_addr", 32'(m_address), 32'h20);
    waitDone("rr_second_wait", 100, d);
    compare("rr_second_done", 32'(d), 32'h2);
    tick(); tick();
    compare("rr_third_grant", 32'(grant), 32'h1);
    req = 2'b00;
    waitDone("rr_dropped_wait", 100, d);
    compare("rr_dropped_done", 32'(d), 32'h1);
    tick(); tick();

    // Reset while waiting for the master to finish.
    force_mode = 4;
    req = 2'b10; addr1 = 7'h33;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!m_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportFail("busy_wait", 50);
    tick(); tick();
    reset = 1'b1;
    tick();
    compare("mid_rst_grant", 32'(grant), 32'd0);
    compare("mid_rst_enable", 32'(m_enable), 32'd0);
    compare("mid_rst_done", 32'(done), 32'd0);
    compare("mid_rst_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    req = 2'b00;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done != 2'b00) cnt++;
    end
    compare("mid_rst_no_done", 32'(cnt), 32'd0);
    force_mode = 1; force_rx = 8'h77;
    req = 2'b01; addr0 = 7'h44;
    waitDone("post_rst_wait", 100, d);
    compare("post_rst_done", 32'(d), 32'h1);
    compare("post_rst_err", 32'(err), 32'h0);
    compare("post_rst_rdata", 32'(rdata), 32'h77);
    compare("post_rst_addr", 32'(m_address), 32'h44);
    req = 2'b00;
    tick(); tick();

    // Randomised traffic against the model.
    force_mode = 0;
    for (int n = 0; n < 4000; n++) begin
      applyStimulus();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
